// File: rtl/mmio_out_dev.sv
// mmio_out_dev: memory-mapped multi-channel output device with coalescing pending flags
// and a round-robin drain onto a single valid/ready output stream.
module mmio_out_dev #(
    parameter  int DATA_W = 32,
    parameter  int NUM_CH = 4,
    localparam int ADDR_W = $clog2(NUM_CH) + 1,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [CH_W-1:0]     out_ch
);
    logic [DATA_W-1:0] ch_q [NUM_CH];
    logic [DATA_W-1:0] ch_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d, clr, set;
    logic [CH_W-1:0]   rr_q, rr_d, grant, idx, oc_q, oc_d;
    logic [DATA_W-1:0] od_q, od_d, status;
    logic              ov_q, ov_d, found, load, wr_hit;
    logic [CH_W-1:0]   waddr;

    assign waddr  = addr[CH_W-1:0];
    assign wr_hit = wr_en && (addr < ADDR_W'(NUM_CH));
    assign load   = !ov_q || out_ready;

    // First pending channel at or after rr_q; CH_W-bit addition wraps since NUM_CH is a power of two.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = rr_q + CH_W'(i);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        clr = '0;
        set = '0;
        if (load && found) clr[grant] = 1'b1;
        if (wr_hit) set[waddr] = 1'b1;
        pend_d = (pend_q & ~clr) | set;
        rr_d   = (load && found) ? grant + CH_W'(1) : rr_q;
        ov_d   = load ? found : ov_q;
        od_d   = (load && found) ? ch_q[grant] : od_q;
        oc_d   = (load && found) ? grant : oc_q;
        for (int c = 0; c < NUM_CH; c++)
            for (int b = 0; b < DATA_W/8; b++)
                ch_d[c][8*b +: 8] = (wr_hit && waddr == CH_W'(c) && byte_en[b]) ? wdata[8*b +: 8]
                                                                                : ch_q[c][8*b +: 8];
    end

    always_comb begin
        status             = '0;
        status[NUM_CH-1:0] = pend_q;
        status[DATA_W-1]   = ov_q;
        rdata = (addr < ADDR_W'(NUM_CH)) ? ch_q[waddr] : (addr == ADDR_W'(NUM_CH)) ? status : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) ch_q[c] <= '0;
            pend_q <= '0;
            rr_q   <= '0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            oc_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) ch_q[c] <= ch_d[c];
            pend_q <= pend_d;
            rr_q   <= rr_d;
            ov_q   <= ov_d;
            od_q   <= od_d;
            oc_q   <= oc_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_ch    = oc_q;
endmodule
